// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1) with a byte FIFO and status register.
// Define UART_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO byte
// START  | start bit, line low
// DATA   | eight data bits, LSB first
// PARITY | even parity of the data byte (UART_PARITY_EN only)
// STOP   | stop bit, line high; pops the next byte without an idle gap
module uart_tx_mmio #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic [2:0]  write_enable,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [31:0]        data_out_q, data_out_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
`ifdef UART_PARITY_EN
  logic               par_q, par_d;
`endif

  logic        store, load, data_store, status_store;
  logic        push, pop, baud_done, fifo_empty;
  logic [7:0]  head;
  logic [31:0] status_word;
  logic        unused_ok;

  assign store        = sel && (write_enable != 3'b000);
  assign load         = sel && (write_enable == 3'b000);
  assign data_store   = store && (addr[3:2] == 2'd0);
  assign status_store = store && (addr[3:2] == 2'd1);
  assign fifo_empty   = (count_q == '0);
  assign head         = fifo_mem[rd_ptr_q];
  assign baud_done    = (baud_q == '0);
  assign unused_ok    = ^{addr[31:4], addr[1:0], data_in[31:8]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full FIFO is still accepted when the FSM pops on the same edge.
  assign push = data_store && ((count_q != FIFO_FULL) || pop);

  always_comb begin
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (data_store && !push) begin
      ovf_d = 1'b1;
    end else if (status_store && data_in[3]) begin
      ovf_d = 1'b0;
    end
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = BAUD_LOAD;
          state_d = S_START;
`ifdef UART_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      S_START: begin
        if (baud_done) begin
          bit_idx_d = 3'd0;
          baud_d    = BAUD_LOAD;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = BAUD_LOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          baud_d  = BAUD_LOAD;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (baud_done) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            baud_d  = BAUD_LOAD;
            state_d = S_START;
`ifdef UART_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line is registered from the next state so tx changes right after the entry edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign status_word = {16'd0, 8'(count_q), 4'd0, ovf_q, (state_q != S_IDLE),
                        fifo_empty, (count_q == FIFO_FULL)};

  always_comb begin
    data_out_d = data_out_q;
    if (load) begin
      case (addr[3:2])
        2'd1:    data_out_d = status_word;
        2'd2:    data_out_d = 32'(CLK_DIV);
        default: data_out_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= data_in[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      data_out_q <= 32'd0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef UART_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register/overflow/reset steps plus random
// bursts; tx is compared every cycle against a frame-level model of the expected line.
module tb_uart_tx_mmio;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [2:0]  write_enable = 3'b000;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        tx;

  uart_tx_mmio #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .write_enable(write_enable),
    .data_in(data_in), .data_out(data_out), .tx(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Line model: a burst of bytes sent back to back, the first start bit entered at edge t0.
  logic [7:0] burst[$];
  int         t0 = 0;
  bit         model_on = 1'b0;

  function automatic logic exp_tx(input int t);
    int rel, f, b;
    if (!model_on || t < t0) return 1'b1;
    rel = t - t0;
    f = rel / FRAME_CYC;
    b = (rel % FRAME_CYC) / CLK_DIV;
    if (f >= burst.size()) return 1'b1;
    if (b == 0) return 1'b0;
    if (b <= 8) return burst[f][b-1];
    if (FRAME_BITS == 11 && b == 9) return ^burst[f];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed 0x%08h expected 0x%08h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("tx", {31'd0, tx}, {31'd0, exp_tx(cyc)});
  endtask

  task automatic bus(input logic [1:0] reg_idx, input logic [2:0] we, input logic [31:0] d);
    logic [31:0] r;
    r = $urandom;
    sel = 1'b1;
    addr = {r[31:4], reg_idx, r[1:0]};
    write_enable = we;
    data_in = d;
    step();
    sel = 1'b0;
    write_enable = 3'b000;
  endtask

  task automatic read(input logic [1:0] reg_idx, output logic [31:0] v);
    bus(reg_idx, 3'b000, $urandom);
    v = data_out;
  endtask

  task automatic begin_burst();
    burst.delete();
    t0 = cyc + 2;
    model_on = 1'b1;
  endtask

  function automatic logic [2:0] rand_we();
    case ($urandom_range(0, 2))
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    logic [31:0] w;
    logic [7:0]  b;
    int          n;
    int          n_acc;

    repeat (3) step();
    check("reset_data_out", data_out, 32'd0);
    check("reset_tx", {31'd0, tx}, 32'd1);
    rst_n = 1'b1;
    step();

    read(2'd1, rd); check("status_after_reset", rd, 32'h0000_0002);
    read(2'd2, rd); check("div_read", rd, CLK_DIV);
    read(2'd3, rd); check("reg3_read", rd, 32'd0);
    read(2'd0, rd); check("data_read", rd, 32'd0);
    bus(2'd2, 3'b001, 32'hFFFF_FFFF);
    bus(2'd3, 3'b100, 32'h0000_00FF);
    read(2'd1, rd); check("ignored_stores", rd, 32'h0000_0002);

    // Single byte, STATUS polled every cycle to time busy and empty.
    begin_burst();
    burst.push_back(8'hA5);
    bus(2'd0, 3'b100, 32'hDEAD_BEA5);
    for (int i = 1; i <= FRAME_CYC + 2; i++) begin
      read(2'd1, rd);
      if (i == 1)                   check("poll_status", rd, 32'h0000_0100);
      else if (i <= FRAME_CYC + 1)  check("poll_status", rd, 32'h0000_0006);
      else                          check("poll_status", rd, 32'h0000_0002);
    end

    // Back-to-back word stores, frames must abut.
    begin_burst();
    burst.push_back(8'h55);
    burst.push_back(8'hAA);
    bus(2'd0, 3'b001, 32'h1234_5655);
    bus(2'd0, 3'b001, 32'h0000_00AA);
    repeat (2 * FRAME_CYC + 4) step();
    read(2'd1, rd); check("b2b_done", rd, 32'h0000_0002);

    // Overflow: six stores while the first frame runs.
    begin_burst();
    b = 8'($urandom);
    burst.push_back(b);
    bus(2'd0, 3'b100, {24'd0, b});
    n_acc = (6 < DEPTH) ? 6 : DEPTH;
    for (int k = 0; k < 6; k++) begin
      w = $urandom;
      bus(2'd0, rand_we(), w);
      if (k < n_acc) burst.push_back(w[7:0]);
    end
    read(2'd1, rd); check("ovf_status", rd, (32'(n_acc) << 8) | 32'h0000_000D);
    bus(2'd1, 3'b001, 32'h0000_0000);
    read(2'd1, rd); check("ovf_no_clear", rd, (32'(n_acc) << 8) | 32'h0000_000D);
    bus(2'd1, 3'b001, 32'h0000_0008);
    read(2'd1, rd); check("ovf_cleared", rd, (32'(n_acc) << 8) | 32'h0000_0005);
    repeat ((n_acc + 1) * FRAME_CYC) step();
    read(2'd1, rd); check("ovf_drain_done", rd, 32'h0000_0002);

    // Parity-sensitive bytes (odd and even population).
    begin_burst();
    burst.push_back(8'h07);
    burst.push_back(8'h03);
    bus(2'd0, 3'b100, 32'h0000_0007);
    bus(2'd0, 3'b010, 32'h0000_0003);
    repeat (2 * FRAME_CYC + 4) step();
    read(2'd1, rd); check("parity_done", rd, 32'h0000_0002);

    // Random bursts with random strobe widths and gaps.
    for (int r = 0; r < 6; r++) begin
      begin_burst();
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        w = $urandom;
        burst.push_back(w[7:0]);
        bus(2'd0, rand_we(), w);
        if (j < n - 1) repeat ($urandom_range(0, 2)) step();
      end
      repeat (n * FRAME_CYC + 4) step();
      read(2'd1, rd); check("rand_burst_done", rd, 32'h0000_0002);
    end

    // Reset in the middle of a data bit with more bytes queued.
    begin_burst();
    burst.push_back(8'h00);
    burst.push_back(8'h5A);
    bus(2'd0, 3'b100, 32'h0000_0000);
    bus(2'd0, 3'b100, 32'h0000_005A);
    bus(2'd0, 3'b100, 32'h0000_00C3);
    repeat (2 * CLK_DIV + 2) step();
    model_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    check("async_reset_data_out", data_out, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    read(2'd1, rd); check("status_after_mid_reset", rd, 32'h0000_0002);
    repeat (3 * FRAME_CYC) step();
    read(2'd1, rd); check("no_frames_after_reset", rd, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter with a byte FIFO, attached to the core's data-memory port alongside RAM and GPIO. The memory decoder routes stores and loads here when the address falls in the UART window. It uses the same 3-bit store-width encoding and one-cycle registered read latency as the rest of the data path. Software enqueues bytes with stores and polls a status word with loads. The block serialises bytes 8N1 on `tx`.

## Interface
Parameters:
- `CLK_DIV`, 104: clock cycles per bit; must be at least 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, at most 128.

Ports:
- `clk`  in  1  core clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sel`  in  1  address-decode hit for the UART window.
- `addr`  in  32  byte address; only `addr[3:2]` is decoded.
- `write_enable`  in  3  store strobe: `100` byte, `010` half, `001` word, `000` no write.
- `data_in`  in  32  store data.
- `data_out`  out  32  registered load data.
- `tx`  out  1  serial line; idles high.

## Operation
Register map (`addr[3:2]`):
- 0 DATA
  - Any store with nonzero `write_enable` enqueues `data_in[7:0]`.
  - Reads return 0.
- 1 STATUS, read-only except for bit 3.
  - Bit 0: full.
  - Bit 1: empty.
  - Bit 2: busy (FSM not IDLE).
  - Bit 3: overflow, sticky. A store to STATUS with `data_in[3]=1` clears it.
  - Bits [15:8]: FIFO count.
  - All other bits read 0.
- 2 DIV: reads return `CLK_DIV`; stores are ignored.
- 3: reads return 0; stores are ignored.

FIFO:
- Circular buffer with read/write pointers and a count. Pointers wrap modulo `FIFO_DEPTH`.
- Enqueue when a DATA store occurs and either count < `FIFO_DEPTH`, or a pop happens on the same edge.
- Otherwise the byte is dropped and overflow is set.
- Simultaneous push and pop leave the count unchanged.

TX FSM states: IDLE, START, DATA, STOP (plus PARITY with the macro).
- IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
- START: `tx`=0 for `CLK_DIV` cycles, then DATA with bit index 0.
- DATA: `tx`=shift[0], LSB first. Each bit lasts `CLK_DIV` cycles. After bit 7, go to STOP.
- STOP: `tx`=1 for `CLK_DIV` cycles.
  - If the FIFO is non-empty at the end, pop and go straight to START (no idle gap).
  - Otherwise go to IDLE.
- Baud counter: loads `CLK_DIV-1` on every state or bit entry and counts down. The bit ends when the counter reads 0.

Reset values:
- `tx`=1, `data_out`=0, FSM=IDLE.
- FIFO empty, pointers 0, overflow=0, baud counter 0.
- A reset mid-frame aborts the frame immediately and discards FIFO contents.

## Timing
- Load latency: `data_out` updates on the edge where `sel`=1 and `write_enable`=0, from the address at that edge, and holds its value otherwise. The core samples it one cycle later.
- Store: takes effect on the edge where `sel`=1 and `write_enable`≠0. The strobe is one cycle wide; every strobed cycle counts as a separate store.
- STATUS read on the edge after a store reflects that store.
- Store to DATA at edge E while the FIFO is empty and the FSM is in IDLE:
  - Pop and START entry at E+1; `tx` falls after E+1.
  - Frame is 10×`CLK_DIV` cycles (11× with parity). `tx` returns high for the stop bit after edge E+1+9×`CLK_DIV`.
- Busy is 1 from E+1 until the edge that returns the FSM to IDLE.

## Configuration
- `UART_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP, lasting `CLK_DIV` cycles.
  - `tx` during PARITY = XOR of the 8 data bits (even parity). Frame is 11 bits.
- Undefined: 8N1 only; no PARITY state; 10-bit frame.

## Test plan
Bench parameters: `CLK_DIV`=4, `FIFO_DEPTH`=4.
- Reset, then read STATUS -> `data_out`=0x00000002 and `tx`=1.
- Byte store 0xA5 to DATA at edge E -> `tx`=0 for cycles E+1..E+4, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1. Busy drops at E+41.
- Word store 0x12345655, then 0x000000AA on back-to-back store strobes -> two frames with no idle cycle between stop and start. Data bits are 0x55 then 0xAA.
- Six DATA stores while the first frame is transmitting:
  - Count saturates at 4, overflow=1 (STATUS bit 3).
  - Store 0x8 to STATUS -> overflow=0; count unchanged.
- Assert `rst_n` low mid-DATA bit -> `tx`=1 asynchronously, STATUS reads 0x00000002 after release, no further frames.
- With `UART_PARITY_EN`, send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0. Frame is 44 cycles.
